sha_digest_display: RTL and testbench
=====================================

// Module: sha_digest_display
// PURPOSE
//   Board-level viewer for a SHA-256 (or any wide) digest. Captures the digest on a done
//   pulse and pages through it DIGITS hex nibbles at a time on the multiplexed 7-segment display.
//   Paging is driven by debounced next/prev buttons; LEDs show capture status and page index.
//   Sits between the hash core output and the board pins, in the 50 MHz domain.
// PARAMETERS
//   DIGEST_W        256     digest width in bits; must be a multiple of 4*DIGITS
//   DIGITS          4       number of 7-seg digits (anodes)
//   REFRESH_DIV     50000   clk cycles each digit stays lit (1 kHz/digit at 50 MHz)
//   DEBOUNCE_CYCLES 500000  cycles a synchronised button must be stable to be accepted (10 ms)
//   NPAGES is derived, not a parameter: NPAGES = DIGEST_W/(4*DIGITS) (16 by default).
// PORTS
//   clk           in   1          system clock (clock_50mhz)
//   rst           in   1          asynchronous reset, active-high
//   digest_valid  in   1          1-cycle pulse: digest is final
//   digest        in   DIGEST_W   hash value, MSB = first byte of digest
//   btn_next      in   1          raw async push button: next page
//   btn_prev      in   1          raw async push button: previous page
//   led           out  8          [7] = digest held; [6:0] = current page index (zero-extended)
//   seg           out  7          {g,f,e,d,c,b,a}, active-low
//   dp            out  1          decimal point, active-low
//   an            out  DIGITS     digit enables, active-low one-hot; an[0] = rightmost digit
// BEHAVIOUR
//   Reset, applied asynchronously: held=0, page=0, digest reg=0, digit idx=0, refresh cnt=0,
//     debounce state=0. Outputs: led=0, seg=7'h7F, dp=1, an=all ones.
//   Capture: on digest_valid, latch digest, set held=1 and page=0 on the next edge.
//     A new digest_valid overwrites the held digest; there is no lock.
//   Buttons: 2-FF synchroniser, then a counter. The debounced level changes only after
//     DEBOUNCE_CYCLES consecutive equal samples. One rising edge of the debounced level = one step.
//   Paging: next gives page = (page==NPAGES-1) ? 0 : page+1. Prev gives page = (page==0) ? NPAGES-1 : page-1.
//     Steps are ignored while held=0.
//   Simultaneous events:
//     next and prev edges in the same cycle: page unchanged.
//     digest_valid together with any step: capture wins and page=0.
//   Scan: refresh counter counts 0..REFRESH_DIV-1. At wrap, digit idx d advances 0..DIGITS-1,
//     wrapping to 0. an/seg/dp are registered and change one cycle after d changes.
//   Nibble mapping: page p, digit d shows digest[4*((NPAGES-1-p)*DIGITS + d) +: 4].
//     Page 0 therefore shows the most significant nibbles, leftmost digit first.
//   Hex font (active-low): 0 = 7'h40, 1 = 7'h79, A = 7'h08, b = 7'h03, F = 7'h0E.
//     Full 0-F table is a case ROM.
//   While held=0: an stays all ones (display blank), seg=7'h7F.
//   dp=0 only on digit 0 while page==NPAGES-1 (end-of-digest marker); otherwise dp=1.
//   led updates in the same cycle as page/held, from registers.
//   Reset asserted mid-scan or mid-debounce clears everything. A button held through reset
//     release produces no step until it is released and pressed again.
// TESTING
//   Use REFRESH_DIV=4, DEBOUNCE_CYCLES=8, and digest = SHA-256("abc") =
//     ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//   1. Reset only -> led=0, an=4'hF, seg=7'h7F. Pulse next -> led stays 0.
//   2. Pulse digest_valid -> led=8'h80. Over one scan, digits (left to right) show B,A,7,8;
//      an one-hot low, 4 cycles per digit.
//   3. Clean next press -> led=8'h81, digits 1,6,B,F. Press prev twice -> led=8'h8F
//      (wrap to page 15), digits 1,5,A,D, dp low on an[0].
//   4. next input toggling every 3 cycles for 30 cycles, then stable high -> exactly one step.
//   5. next and prev debounced edges in the same cycle -> page unchanged.
//      digest_valid in the same cycle as next -> page=0.
//   6. Assert rst mid-scan with page=5 -> all outputs go to reset values immediately,
//      with no clock edge needed.

Source files
------------

// File: rtl/sha_digest_display.sv
// Captures a wide digest on a done pulse and pages through it DIGITS hex nibbles
// at a time on a multiplexed active-low 7-segment display, stepped by debounced buttons.
module sha_dd_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_q;

  // Reset assumes "pressed" so a button held through reset cannot produce a rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_q <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_level & ~r_level_q;
endmodule

module sha_digest_display #(
  parameter int DIGEST_W        = 256,
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_digest_valid,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_btn_next,
  input  logic                i_btn_prev,
  output logic [7:0]          o_led,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic [DIGITS-1:0]   o_an
);
  localparam int NPAGES = DIGEST_W / (4 * DIGITS);
  localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic                w_next;
  logic                w_prev;
  logic [31:0]         w_nib_idx;
  logic [3:0]          w_nib;
  logic [6:0]          w_font;

  logic [DIGEST_W-1:0] r_digest;
  logic                r_held;
  logic [PW-1:0]       r_page;
  logic [RW-1:0]       r_ref;
  logic [DW-1:0]       r_d;

  sha_dd_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_next),
    .o_rise(w_next)
  );

  sha_dd_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_prev),
    .o_rise(w_prev)
  );

  // Capture beats any step; opposing steps in one cycle cancel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digest <= '0;
      r_held   <= 1'b0;
      r_page   <= '0;
    end else if (i_digest_valid) begin
      r_digest <= i_digest;
      r_held   <= 1'b1;
      r_page   <= '0;
    end else if (r_held && (w_next ^ w_prev)) begin
      if (w_next)
        r_page <= (r_page == PW'(NPAGES - 1)) ? '0 : r_page + 1'b1;
      else
        r_page <= (r_page == '0) ? PW'(NPAGES - 1) : r_page - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref <= '0;
      r_d   <= '0;
    end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_d   <= (r_d == DW'(DIGITS - 1)) ? '0 : r_d + 1'b1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  assign w_nib_idx = (32'(NPAGES - 1) - 32'(r_page)) * 32'(DIGITS) + 32'(r_d);
  assign w_nib     = 4'(r_digest >> {w_nib_idx, 2'b00});

  always_comb begin
    w_font = 7'h7F;
    case (w_nib)
      4'h0: w_font = 7'h40;
      4'h1: w_font = 7'h79;
      4'h2: w_font = 7'h24;
      4'h3: w_font = 7'h30;
      4'h4: w_font = 7'h19;
      4'h5: w_font = 7'h12;
      4'h6: w_font = 7'h02;
      4'h7: w_font = 7'h78;
      4'h8: w_font = 7'h00;
      4'h9: w_font = 7'h10;
      4'hA: w_font = 7'h08;
      4'hB: w_font = 7'h03;
      4'hC: w_font = 7'h46;
      4'hD: w_font = 7'h21;
      4'hE: w_font = 7'h06;
      4'hF: w_font = 7'h0E;
      default: w_font = 7'h7F;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else if (!r_held) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= ~(DIGITS'(1) << r_d);
      o_seg <= w_font;
      o_dp  <= !((r_d == '0) && (r_page == PW'(NPAGES - 1)));
    end
  end

  assign o_led = {r_held, 7'(r_page)};
endmodule

// File: tb/tb_sha_digest_display.sv
// Directed checks of capture, paging, debounce, scan order and async reset of sha_digest_display.
module tb_sha_digest_display;
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dv = 1'b0;
  logic [255:0] digest = '0;
  logic         bn = 1'b0;
  logic         bp = 1'b0;
  logic [7:0]   led;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;

  int ncmp = 0;
  int nfail = 0;
  int nstep = 0;

  always #5 clk = ~clk;

  sha_digest_display #(
    .DIGEST_W(256), .DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_digest_valid(dv), .i_digest(digest),
    .i_btn_next(bn), .i_btn_prev(bp),
    .o_led(led), .o_seg(seg), .o_dp(dp), .o_an(an)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit nx, input bit pv);
    bn = nx; bp = pv;
    cycles(20);
    bn = 1'b0; bp = 1'b0;
    cycles(20);
  endtask

  task automatic pulse_dv();
    digest = ABC; dv = 1'b1;
    cycles(1);
    dv = 1'b0;
  endtask

  // s3 is the leftmost digit (an[3]); checks font, one-hot anode and 4-cycle dwell
  task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                      input logic [6:0] s0, input bit endp);
    logic [3:0] pan;
    logic [6:0] es;
    int run;
    int nchg;
    pan = '0; run = 0; nchg = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      case (an)
        4'b0111: es = s3;
        4'b1011: es = s2;
        4'b1101: es = s1;
        4'b1110: es = s0;
        default: es = 'x;
      endcase
      chk("an_onehot", $countones(~an), 1);
      chk("seg", {25'd0, seg}, {25'd0, es});
      chk("dp", {31'd0, dp}, (endp && an == 4'b1110) ? 32'd0 : 32'd1);
      if (c == 0) begin
        pan = an; run = 1;
      end else if (an != pan) begin
        if (nchg > 0) chk("dwell", run, 4);
        nchg++; run = 1; pan = an;
      end else begin
        run++;
      end
    end
  endtask

  initial begin
    // 1. reset state, steps ignored while nothing is held
    cycles(3);
    chk("rst_led", led, 8'h00);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    rst = 1'b0;
    cycles(20);
    press(1'b1, 1'b0);
    chk("unheld_next_led", led, 8'h00);
    chk("unheld_an", an, 4'hF);

    // 2. capture and page 0 scan: B A 7 8
    pulse_dv();
    chk("capture_led", led, 8'h80);
    cycles(2);
    scan(7'h03, 7'h08, 7'h78, 7'h00, 1'b0);

    // 3. next -> page 1 (1 6 B F), prev x2 -> page 15 (1 5 A D, dp on an[0])
    bn = 1'b1;
    while (led == 8'h80 && nstep < 40) begin
      @(negedge clk);
      nstep++;
    end
    chk("step_latency_ok", (nstep > 2 && nstep < 40), 1);
    cycles(20);
    bn = 1'b0;
    cycles(20);
    chk("next_led", led, 8'h81);
    scan(7'h79, 7'h02, 7'h03, 7'h0E, 1'b0);
    press(1'b0, 1'b1);
    chk("prev1_led", led, 8'h80);
    press(1'b0, 1'b1);
    chk("prev_wrap_led", led, 8'h8F);
    scan(7'h79, 7'h12, 7'h08, 7'h21, 1'b1);

    // 4. bouncing next then stable: one step, page 15 wraps to 0
    for (int t = 0; t < 10; t++) begin
      bn = ~bn;
      cycles(3);
    end
    bn = 1'b1;
    cycles(20);
    bn = 1'b0;
    cycles(20);
    chk("bounce_one_step", led, 8'h80);

    // 5. opposing edges cancel; capture beats a simultaneous step
    press(1'b1, 1'b0);
    chk("next_again", led, 8'h81);
    press(1'b1, 1'b1);
    chk("both_cancel", led, 8'h81);
    bn = 1'b1;
    cycles(nstep - 1);
    digest = ABC; dv = 1'b1;
    cycles(1);
    dv = 1'b0;
    chk("capture_wins", led, 8'h80);
    cycles(20);
    bn = 1'b0;
    cycles(20);
    chk("capture_wins_after", led, 8'h80);

    // 6. async reset mid-scan at page 5
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0);
    chk("page5_led", led, 8'h85);
    cycles(6);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_led", led, 8'h00);
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);

    // button held through reset release must not step
    bn = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(30);
    pulse_dv();
    cycles(30);
    chk("held_through_rst", led, 8'h80);
    bn = 1'b0;
    cycles(20);
    press(1'b1, 1'b0);
    chk("repress_after_rst", led, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
